// File: rtl/fsm_symbol_tx_if.sv
// fsm_symbol_tx_if: handshake/symbol bundle between a frame source and the
// symbol transmitter.
//   master : drives load/data, observes everything else
//   slave  : the transmitter; samples load/data, drives ready/busy/x_out/
//            x_valid/done (plus peer_state/peer_out with
//            FSM_SYMBOL_TX_SHADOW_EN defined)
interface fsm_symbol_tx_if #(parameter int NSYM = 8);
  logic              load;
  logic [2*NSYM-1:0] data;
  logic              ready;
  logic              busy;
  logic [1:0]        x_out;
  logic              x_valid;
  logic              done;
`ifdef FSM_SYMBOL_TX_SHADOW_EN
  logic [1:0]        peer_state;
  logic              peer_out;

  modport master (output load, data,
                  input  ready, busy, x_out, x_valid, done, peer_state, peer_out);
  modport slave  (input  load, data,
                  output ready, busy, x_out, x_valid, done, peer_state, peer_out);
`else
  modport master (output load, data,
                  input  ready, busy, x_out, x_valid, done);
  modport slave  (input  load, data,
                  output ready, busy, x_out, x_valid, done);
`endif
endinterface

// File: rtl/fsm_symbol_tx.sv
// fsm_symbol_tx: serializes a 2*NSYM-bit frame word into NSYM 2-bit symbols,
// MSB symbol first, one per clock, followed by GAP idle cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fsm_symbol_tx_if.slave (load/data in; ready/busy/x_out/x_valid/
//          done out; peer_state/peer_out with the shadow receiver)
// Optional feature: define FSM_SYMBOL_TX_SHADOW_EN to build a shadow copy of
// the four-state receiver FSM driven by the transmitted symbols.
module fsm_symbol_tx #(
  parameter int NSYM = 8,
  parameter int GAP  = 2
) (
  input  logic          clk,
  input  logic          rst,
  fsm_symbol_tx_if.slave bus
);
  localparam int W     = 2*NSYM;
  localparam int CW    = $clog2(NSYM);
  // GAP=0 would give a zero-width counter; keep one bit that is never used.
  localparam int GW    = (GAP > 0) ? $clog2(GAP+1) : 1;
  localparam int GLAST = (GAP > 0) ? GAP-1 : 0;

  typedef enum logic [1:0] {IDLE, SEND, GAPS} st_t;

  st_t           state, state_n;
  logic [W-1:0]  sh, sh_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [1:0]    xo, xo_n;
  logic          xv, xv_n;
  logic          dn, dn_n;
  logic          last, gap_end;

  assign last    = (cnt == CW'(NSYM-1));
  assign gap_end = (gcnt == GW'(GLAST));

  // State register plus all registered outputs/datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      gcnt  <= '0;
      xo    <= 2'b00;
      xv    <= 1'b0;
      dn    <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      gcnt  <= gcnt_n;
      xo    <= xo_n;
      xv    <= xv_n;
      dn    <= dn_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.load) state_n = SEND;
      SEND:    if (last)     state_n = (GAP > 0) ? GAPS : IDLE;
      GAPS:    if (gap_end)  state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  // Output/datapath next values. x_out is registered, so the symbol that
  // appears in a cycle is selected one edge early: symbol 0 straight from
  // data on the load edge, later symbols from the already-shifted register.
  always_comb begin
    sh_n   = sh;
    cnt_n  = cnt;
    gcnt_n = gcnt;
    xo_n   = 2'b00;
    xv_n   = 1'b0;
    dn_n   = 1'b0;
    case (state)
      IDLE: if (bus.load) begin
        xo_n  = bus.data[W-1 -: 2];
        xv_n  = 1'b1;
        sh_n  = bus.data << 2;
        cnt_n = '0;
      end
      SEND: if (!last) begin
        xo_n  = sh[W-1 -: 2];
        xv_n  = 1'b1;
        sh_n  = sh << 2;
        cnt_n = cnt + 1'b1;
      end else begin
        dn_n   = 1'b1;
        gcnt_n = '0;
      end
      GAPS: if (!gap_end) gcnt_n = gcnt + 1'b1;
      default: ;
    endcase
  end

  assign bus.ready   = (state == IDLE);
  assign bus.busy    = (state != IDLE);
  assign bus.x_out   = xo;
  assign bus.x_valid = xv;
  assign bus.done    = dn;

`ifdef FSM_SYMBOL_TX_SHADOW_EN
  // Shadow receiver: advances on each valid symbol, holds otherwise.
  logic [1:0] ps, ps_n;
  logic       po;

  always_comb begin
    ps_n = ps;
    if (xv) begin
      if (ps == 2'd3) begin
        case (xo)
          2'b00:   ps_n = 2'd2;
          2'b01:   ps_n = 2'd1;
          2'b10:   ps_n = 2'd0;
          default: ps_n = 2'd3;
        endcase
      end else begin
        ps_n = xo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps <= 2'd0;
      po <= 1'b0;
    end else begin
      ps <= ps_n;
      po <= (ps_n == 2'd1);
    end
  end

  assign bus.peer_state = ps;
  assign bus.peer_out   = po;
`endif
endmodule

// File: doc/fsm_symbol_tx.md
# fsm_symbol_tx

Frame transmitter that drives 2-bit symbols into the four-state symbol-stream FSM. It sends one frame per load over a `x_out`/`x_valid` interface, one symbol per clock. A parameter-sized word is accepted in a single load handshake and serialized MSB-symbol first. A fixed idle gap follows each frame, giving the receiving FSM settling time between frames.

## Interface
- `NSYM`, 8: symbols per frame (≥2); frame word is 2*NSYM bits.
- `GAP`, 2: idle cycles inserted after each frame (≥0).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `load`  in  1  frame request; accepted only when `ready`=1.
- `data`  in  2*NSYM  frame word; symbol k = `data[2*NSYM-1-2k -: 2]`.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  inverse of `ready`.
- `x_out`  out  2  current symbol; 2'b00 whenever `x_valid`=0.
- `x_valid`  out  1  `x_out` carries a frame symbol this cycle.
- `done`  out  1  one-cycle pulse after the last symbol.
- `peer_state`  out  2  shadow receiver state (only with macro).
- `peer_out`  out  1  shadow receiver output (only with macro).

## Operation
- States: IDLE, SEND, GAP.
- **IDLE**
  - `ready`=1.
  - `load`=1: capture `data` into the shift register, clear the symbol counter, go to SEND.
- **SEND**
  - `x_valid`=1; `x_out` = top 2 bits of the shift register.
  - Each cycle: shift left by 2 and increment the counter.
  - After symbol NSYM-1: go to GAP if GAP>0, else IDLE.
- **GAP**
  - `x_valid`=0, `x_out`=00.
  - Counts GAP cycles, then returns to IDLE.
- `done`: registered, high for exactly one cycle, in the first cycle after the last symbol (first GAP cycle, or first IDLE cycle when GAP=0).
- `load` outside IDLE is ignored; `data` is not re-sampled.
- Back-to-back frames: `load` in the first IDLE cycle restarts SEND on the next edge.
- Counter width is `$clog2(NSYM)` for SEND and `$clog2(GAP+1)` for GAP; no wrap beyond NSYM-1.
- Reset, including mid-frame:
  - state IDLE, shift register 0, counters 0.
  - `x_out`=00, `x_valid`=0, `done`=0, `ready`=1, `busy`=0.
  - Shadow state s0, `peer_out`=0.
  - The in-flight frame is dropped with no `done`.

## Timing
- Load accepted at edge T: symbol 0 is valid in cycle T+1; symbol k in cycle T+1+k.
- Last symbol in cycle T+NSYM; `done` in cycle T+NSYM+1.
- `ready` rises in cycle T+NSYM+1+GAP.
- Frame period is NSYM+GAP+1 cycles, plus 1 more if the next `load` is late.
- All outputs are registered except `ready`/`busy`, which decode the state register.

## Configuration
- Macro `FSM_SYMBOL_TX_SHADOW_EN`.
- **Defined:** a shadow copy of the receiver FSM updates on every edge where `x_valid`=1.
  - From s0, s1, s2: next state = symbol (00→s0, 01→s1, 10→s2, 11→s3).
  - From s3: 00→s2, 01→s1, 10→s0, 11→s3.
  - `peer_state` is the shadow state, visible the cycle after each symbol.
  - `peer_out`=1 only in s1 (Moore).
  - The shadow holds during GAP and IDLE; only reset returns it to s0.
- **Undefined:** `peer_state` and `peer_out` are absent from the port list and no shadow logic is built.

## Test plan
- **Reset idle:** assert `rst` mid-clock.
  - → `x_valid`=0, `x_out`=00, `done`=0, `ready`=1 immediately.
  - → `peer_state`=00 with macro.
- **Basic frame:** NSYM=8, GAP=2, `load` with `data`=16'hE41B.
  - → `x_out` sequence 11,10,01,00,00,01,10,11 on 8 consecutive cycles.
  - → `done` one cycle later; `ready` after 2 gap cycles.
- **Shadow tracking (macro):** same frame.
  - → `peer_state` sequence s3,s0,s1,s0,s0,s1,s2,s3.
  - → `peer_out` 0,0,1,0,0,1,0,0; final state s3.
- **Load while busy:** pulse `load` with 16'hFFFF during SEND and GAP.
  - → original symbols are unchanged; exactly one `done`.
- **GAP=0 back-to-back:** hold `load`=1 with 16'h0000 then 16'h5555.
  - → 8×00, then `done`+IDLE for 1 cycle, then 8×01.
  - → no gap cycles; two `done` pulses.
- **Reset mid-frame:** assert `rst` during symbol 3.
  - → outputs clear asynchronously; no `done`.
  - → next `load` of 16'hE41B is transmitted in full from symbol 0.
